// File: rtl/ram_async_sequencer.sv
// Asynchronous-mode CellularRAM access sequencer: turns one host req/ack transaction
// into timed CE#/ADV#/OE#/WE#/UB#/LB#/CRE strobes with a tristated data bus.
module ram_async_sequencer #(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16,
  parameter int RD_CYCLES    = 7,
  parameter int WR_CYCLES    = 6,
  parameter int REC_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hostReq,
  input  logic                    hostWr,
  input  logic                    hostCfg,
  input  logic [ADDRESS_SIZE-1:0] hostAddr,
  input  logic [DATA_SIZE-1:0]    hostWData,
  input  logic [1:0]              hostByteEn,
  output logic                    hostAck,
  output logic [DATA_SIZE-1:0]    hostRData,
  output logic                    busy,
  output logic [ADDRESS_SIZE-1:0] outAddress,
  inout  wire  [DATA_SIZE-1:0]    outData,
  output logic                    lowerByte,
  output logic                    upperByte,
  output logic                    outputEnable,
  output logic                    writeEnable,
  output logic                    mt_clk,
  output logic                    mt_adv,
  output logic                    mt_cre,
  output logic                    mt_ce,
  input  logic                    mt_wait
);

  localparam int RW_MAX  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_MAX = (RW_MAX > REC_CYCLES) ? RW_MAX : REC_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WRITE,
    CFG_WRITE,
    RECOVER
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 wr_q;
  logic                 cfg_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic                 drive;

  // Host handshake: hostReq is only looked at while idle; once accepted, the request
  // fields are latched and hostAck pulses for exactly one clock when the RAM access
  // completes. A request still high after that pulse starts a new access once idle.

  // Async mode: the RAM clock is parked low and WAIT is never consulted.
  assign mt_clk = 1'b0;

  logic unused_wait;
  assign unused_wait = mt_wait;

  // The bus is only driven while WE# is low, so it can never overlap OE#.
  assign outData = drive ? wdata_q : {DATA_SIZE{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_q         <= 1'b0;
      cfg_q        <= 1'b0;
      wdata_q      <= '0;
      drive        <= 1'b0;
      hostAck      <= 1'b0;
      hostRData    <= '0;
      busy         <= 1'b0;
      outAddress   <= '0;
      lowerByte    <= 1'b1;
      upperByte    <= 1'b1;
      outputEnable <= 1'b1;
      writeEnable  <= 1'b1;
      mt_adv       <= 1'b1;
      mt_cre       <= 1'b0;
      mt_ce        <= 1'b1;
    end else begin
      hostAck <= 1'b0;
      case (state)
        IDLE: begin
          if (hostReq) begin
            state      <= SETUP;
            busy       <= 1'b1;
            wr_q       <= hostWr;
            cfg_q      <= hostCfg;
            wdata_q    <= hostWData;
            outAddress <= hostAddr;
            mt_ce      <= 1'b0;
            mt_adv     <= 1'b0;
            mt_cre     <= hostCfg;
            // Config writes always enable both lanes regardless of hostByteEn.
            upperByte  <= hostCfg ? 1'b0 : ~hostByteEn[1];
            lowerByte  <= hostCfg ? 1'b0 : ~hostByteEn[0];
          end
        end

        SETUP: begin
          if (cfg_q) begin
            state       <= CFG_WRITE;
            cnt         <= WR_LOAD;
            writeEnable <= 1'b0;
            drive       <= 1'b1;
          end else if (wr_q) begin
            state       <= WRITE;
            cnt         <= WR_LOAD;
            writeEnable <= 1'b0;
            drive       <= 1'b1;
          end else begin
            state        <= READ;
            cnt          <= RD_LOAD;
            outputEnable <= 1'b0;
          end
        end

        READ, WRITE, CFG_WRITE: begin
          if (cnt == CNT_ONE) begin
            if (state == READ) begin
              hostRData <= outData;
            end
            state        <= RECOVER;
            cnt          <= REC_LOAD;
            hostAck      <= 1'b1;
            drive        <= 1'b0;
            mt_ce        <= 1'b1;
            mt_adv       <= 1'b1;
            mt_cre       <= 1'b0;
            outputEnable <= 1'b1;
            writeEnable  <= 1'b1;
            upperByte    <= 1'b1;
            lowerByte    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        RECOVER: begin
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_async_sequencer.sv
// Bench for ram_async_sequencer: RAM pin model, table-driven directed accesses,
// hand-written multi-cycle corner cases and randomized accesses against a reference model.
module tb_ram_async_sequencer;

  localparam int RD  = 7;
  localparam int WR  = 6;
  localparam int REC = 2;
  localparam logic [6:0] IDLE_PINS = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hostReq = 1'b0;
  logic        hostWr = 1'b0;
  logic        hostCfg = 1'b0;
  logic [23:0] hostAddr = '0;
  logic [15:0] hostWData = '0;
  logic [1:0]  hostByteEn = '0;
  logic        hostAck;
  logic [15:0] hostRData;
  logic        busy;
  logic [23:0] outAddress;
  wire  [15:0] outData;
  logic        lowerByte, upperByte, outputEnable, writeEnable;
  logic        mt_clk, mt_adv, mt_cre, mt_ce;
  logic        mt_wait = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  logic wait_rand = 1'b0;
  logic trace_on = 1'b0;
  logic [79:0] tr_q[$];
  logic [79:0] ref_tr[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ram_async_sequencer dut (
    .clk(clk), .rst_n(rst_n), .hostReq(hostReq), .hostWr(hostWr), .hostCfg(hostCfg),
    .hostAddr(hostAddr), .hostWData(hostWData), .hostByteEn(hostByteEn),
    .hostAck(hostAck), .hostRData(hostRData), .busy(busy), .outAddress(outAddress),
    .outData(outData), .lowerByte(lowerByte), .upperByte(upperByte),
    .outputEnable(outputEnable), .writeEnable(writeEnable), .mt_clk(mt_clk),
    .mt_adv(mt_adv), .mt_cre(mt_cre), .mt_ce(mt_ce), .mt_wait(mt_wait)
  );

  // RAM array contents, unwritten words hold an address-derived pattern.
  function automatic logic [15:0] dflt(input logic [23:0] a);
    return a[15:0] ^ 16'h3C3C;
  endfunction

  // Pin-level RAM model: drives data while selected with OE# low, latches enabled lanes while WE# low.
  logic [15:0] pin_mem [logic [23:0]];
  logic [15:0] ram_rd = '0;
  logic [15:0] ram_w;
  assign outData = (!mt_ce && !outputEnable && !mt_cre) ? ram_rd : 16'hzzzz;

  always @(negedge clk) begin
    if (!mt_ce && !writeEnable && !mt_cre) begin
      ram_w = pin_mem.exists(outAddress) ? pin_mem[outAddress] : dflt(outAddress);
      if (!lowerByte) ram_w[7:0] = outData[7:0];
      if (!upperByte) ram_w[15:8] = outData[15:8];
      pin_mem[outAddress] = ram_w;
    end
    ram_rd = pin_mem.exists(outAddress) ? pin_mem[outAddress] : dflt(outAddress);
  end

  // Reference memory: what a host expects to read back given its own write history.
  logic [15:0] ref_mem [logic [23:0]];

  function automatic logic [15:0] ref_read(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic ref_write(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] w;
    w = ref_read(a);
    if (be[0]) w[7:0] = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    ref_mem[a] = w;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mt_wait = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (trace_on)
      tr_q.push_back({mt_clk, mt_ce, mt_adv, outputEnable, writeEnable, upperByte, lowerByte,
                      mt_cre, outAddress, hostAck, busy, hostRData,
                      (writeEnable ? 16'h0000 : outData)});
  end

  function automatic logic [6:0] pins();
    return {mt_ce, mt_adv, outputEnable, writeEnable, upperByte, lowerByte, mt_cre};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hostReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete access: setup pins, strobe widths, data, ack, recovery length.
  task automatic run_access(input logic wr, input logic cfg, input logic [23:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be,
                            input logic [1:0] exp_ubl, input logic exp_cre);
    logic is_rd;
    logic [6:0] exp_act;
    logic [15:0] exp_rd;
    int cyc, oe_n, we_n, bad;
    is_rd = !wr && !cfg;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    @(negedge clk);
    hostReq = 1'b1; hostWr = wr; hostCfg = cfg;
    hostAddr = addr; hostWData = wdata; hostByteEn = be;
    @(negedge clk);
    hostReq = 1'b0; hostWr = 1'($urandom_range(0, 1)); hostCfg = 1'($urandom_range(0, 1));
    hostAddr = 24'($urandom); hostWData = 16'($urandom); hostByteEn = 2'($urandom_range(0, 3));
    check("setup_pins", pins(), {4'b0011, exp_ubl, exp_cre});
    check("setup_addr", outAddress, addr);
    check("setup_busy_ack", {busy, hostAck}, 2'b10);
    exp_act = is_rd ? {4'b0001, exp_ubl, 1'b0} : {4'b0010, exp_ubl, exp_cre};
    cyc = 0; oe_n = 0; we_n = 0; bad = 0;
    while (!hostAck && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!hostAck) begin
        if (!outputEnable) oe_n++;
        if (!writeEnable) begin
          we_n++;
          if (outData !== wdata) bad++;
        end
        if (pins() !== exp_act || outAddress !== addr) bad++;
      end
    end
    check("ack_seen", hostAck, 1);
    check("ack_latency", cyc, (is_rd ? RD : WR) + 1);
    check("oe_cycles", oe_n, is_rd ? RD : 0);
    check("we_cycles", we_n, is_rd ? 0 : WR);
    check("active_pins_data", bad, 0);
    check("ack_pins", pins(), IDLE_PINS);
    if (is_rd) begin
      exp_rd = exp_q.pop_front();
      check("read_data", hostRData, exp_rd);
    end
    cyc = 0; bad = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hostAck || pins() !== IDLE_PINS) bad++;
    end
    check("recover_len", cyc, REC);
    check("recover_quiet", bad, 0);
  endtask

  typedef struct {
    logic        wr;
    logic        cfg;
    logic [23:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [1:0]  exp_ubl;
    logic        exp_cre;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cyc, oe_n, bad, nmin;
    logic wr, cfg;
    logic [23:0] addr;
    logic [15:0] wd;
    logic [1:0] be;

    vecs[0]  = '{1'b0, 1'b0, 24'h001234, 16'h0000, 2'b11, 2'b00, 1'b0, 16'hBEEF};
    vecs[1]  = '{1'b1, 1'b0, 24'h7FFFFF, 16'h5A5A, 2'b01, 2'b10, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 24'h080000, 16'h0000, 2'b11, 2'b00, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 24'h7FFFFF, 16'h0000, 2'b11, 2'b00, 1'b0, 16'hC35A};
    vecs[4]  = '{1'b0, 1'b0, 24'h000020, 16'h0000, 2'b00, 2'b11, 1'b0, 16'h3C1C};
    vecs[5]  = '{1'b1, 1'b1, 24'h000030, 16'h1111, 2'b10, 2'b00, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 24'h000030, 16'h0000, 2'b11, 2'b00, 1'b0, 16'h3C0C};
    vecs[7]  = '{1'b1, 1'b0, 24'h000040, 16'hA5A5, 2'b10, 2'b01, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 24'h000040, 16'h0000, 2'b10, 2'b01, 1'b0, 16'hA57C};
    vecs[9]  = '{1'b1, 1'b0, 24'h000050, 16'h9999, 2'b00, 2'b11, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 24'h000050, 16'h0000, 2'b01, 2'b10, 1'b0, 16'h3C6C};

    pin_mem[24'h001234] = 16'hBEEF;
    ref_mem[24'h001234] = 16'hBEEF;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_pins", pins(), IDLE_PINS);
    check("reset_ack_busy", {hostAck, busy}, 2'b00);
    check("reset_rdata", hostRData, 16'h0000);
    check("reset_addr", outAddress, 24'h000000);
    check("reset_mt_clk", mt_clk, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      if (!vecs[i].wr && !vecs[i].cfg) exp_q.push_back(vecs[i].exp_rd);
      else if (!vecs[i].cfg) ref_write(vecs[i].addr, vecs[i].wd, vecs[i].be);
      run_access(vecs[i].wr, vecs[i].cfg, vecs[i].addr, vecs[i].wd, vecs[i].be,
                 vecs[i].exp_ubl, vecs[i].exp_cre);
    end

    // Back-to-back: hostReq held through ack; next CE# low after recovery plus the idle sampling clock
    @(negedge clk);
    hostReq = 1'b1; hostWr = 1'b0; hostCfg = 1'b0; hostAddr = 24'h001234; hostByteEn = 2'b11;
    cyc = 0;
    while (!hostAck && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_ack1", hostAck, 1);
    check("b2b_rdata1", hostRData, 16'hBEEF);
    cyc = 0;
    while (mt_ce && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_gap", cyc, REC + 1);
    check("b2b_setup_addr", outAddress, 24'h001234);
    hostReq = 1'b0;
    cyc = 0;
    while (!hostAck && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_ack2", hostAck, 1);
    cyc = 0;
    while (busy && cyc < 40) begin @(negedge clk); cyc++; end
    bad = 0;
    repeat (4) begin @(negedge clk); if (!mt_ce || busy) bad++; end
    check("b2b_no_third", bad, 0);

    // Reset during the third READ clock
    @(negedge clk);
    hostReq = 1'b1; hostWr = 1'b0; hostCfg = 1'b0; hostAddr = 24'h000777; hostByteEn = 2'b11;
    @(negedge clk);
    hostReq = 1'b0;
    cyc = 0; oe_n = 0;
    while (oe_n < 3 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (!outputEnable) oe_n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pins", pins(), IDLE_PINS);
    check("midrst_ack_busy", {hostAck, busy}, 2'b00);
    check("midrst_rdata", hostRData, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (hostAck || busy || pins() !== IDLE_PINS) bad++;
    end
    check("midrst_idle_after", bad, 0);
    exp_q.push_back(16'hBEEF);
    run_access(1'b0, 1'b0, 24'h001234, 16'h0000, 2'b11, 2'b00, 1'b0);

    // Same access sequence with mt_wait quiet and then toggling: pin traces must match
    for (int run = 0; run < 2; run++) begin
      do_reset();
      wait_rand = (run == 1);
      #1 trace_on = 1'b1;
      ref_write(24'h000010, 16'h1357, 2'b11);
      run_access(1'b1, 1'b0, 24'h000010, 16'h1357, 2'b11, 2'b00, 1'b0);
      exp_q.push_back(16'h1357);
      run_access(1'b0, 1'b0, 24'h000010, 16'h0000, 2'b11, 2'b00, 1'b0);
      run_access(1'b0, 1'b1, 24'h080000, 16'h0000, 2'b01, 2'b00, 1'b1);
      repeat (3) @(negedge clk);
      #1 trace_on = 1'b0;
      if (run == 0) begin
        ref_tr = tr_q;
        tr_q.delete();
      end
    end
    check("wait_trace_len", tr_q.size(), ref_tr.size());
    nmin = (tr_q.size() < ref_tr.size()) ? tr_q.size() : ref_tr.size();
    bad = 0;
    for (int i = 0; i < nmin; i++) if (tr_q[i] !== ref_tr[i]) bad++;
    check("wait_trace_match", bad, 0);

    // Randomized accesses against the reference memory, mt_wait still toggling
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      cfg = ($urandom_range(0, 7) == 0);
      addr = 24'h000100 + 24'($urandom_range(0, 7));
      wd = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      if (!cfg && wr) ref_write(addr, wd, be);
      else if (!cfg) exp_q.push_back(ref_read(addr));
      run_access(wr, cfg, addr, wd, be, cfg ? 2'b00 : ~be, cfg);
    end
    wait_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
